// File: rtl/keypad_scan_fifo.sv
// ROWS x COLS matrix keypad scanner with per-key debounce, press-event FIFO and bus registers.
// Optional interrupt output and CTRL[2] irq_enable are built when KEYPAD_SCAN_IRQ_EN is defined.
module keypad_scan_fifo #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Select,
  input  logic            Read_enable,
  input  logic            Write_enable,
  input  logic [3:0]      Address,
  input  logic [15:0]     Write_data,
  output logic [ROWS-1:0] Row,
  input  logic [COLS-1:0] Column,
  output logic [15:0]     Read_data_out
`ifdef KEYPAD_SCAN_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned CLW = $clog2(COLS);
  localparam int unsigned DW  = $clog2(SCAN_DIV);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned NW  = PW + 1;

  localparam logic [3:0] DebTarget = 4'(DEBOUNCE_TICKS);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StScan     = 2'd1;
  localparam logic [1:0] StDebPress = 2'd2;
  localparam logic [1:0] StHeld     = 2'd3;

  logic [DW-1:0]   div_q, div_d;
  logic            tick;
  logic [1:0]      state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [3:0]      deb_q, deb_d, deb_next;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic            push;
  logic [5:0]      push_code;
  logic            col_any;
  logic [CLW-1:0]  col_low_idx;

  logic            enable_q, enable_d;
  logic            irq_en;
  logic            flush;
  logic            bus_rd, bus_wr, ctrl_wr, pop, status_clr;

  logic [5:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            do_push, full, wr_ok, ovf_set, not_empty;

  logic [15:0]     rd_q, rd_d, rd_mux;

  logic            unused_wdata;
  assign unused_wdata = ^Write_data[15:2];

  // Bus decode
  assign bus_rd     = Select & Read_enable;
  assign bus_wr     = Select & Write_enable;
  assign ctrl_wr    = bus_wr && (Address == 4'h4);
  assign enable_d   = ctrl_wr ? Write_data[0] : enable_q;
  assign flush      = ctrl_wr & Write_data[1];
  assign not_empty  = (count_q != '0);
  assign pop        = bus_rd && (Address == 4'h0) && not_empty;
  assign status_clr = bus_rd && (Address == 4'h2);

`ifdef KEYPAD_SCAN_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
  assign irq_en_d = ctrl_wr ? Write_data[2] : irq_en_q;
  assign irq_en   = irq_en_q;
  assign irq      = irq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q & (not_empty | ovf_q);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // Scan divider
  assign tick  = enable_q && (div_q == DW'(SCAN_DIV - 1));
  assign div_d = (!enable_d || tick) ? '0 : div_q + DW'(1);

  // Lowest-indexed low column wins
  always_comb begin
    col_low_idx = '0;
    for (int i = int'(COLS) - 1; i >= 0; i--) begin
      if (!Column[i]) col_low_idx = CLW'(i);
    end
  end
  assign col_any  = ~&Column;
  assign deb_next = deb_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    deb_d     = deb_q;
    push      = 1'b0;
    push_code = 6'(row_q) * 6'(COLS) + 6'(col_q);
    if (!enable_d) begin
      state_d = StIdle;
      row_d   = '0;
      deb_d   = '0;
    end else if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (col_any) begin
            state_d = StScan;
            row_d   = '0;
          end
        end
        StScan: begin
          if (col_any) begin
            col_d = col_low_idx;
            deb_d = 4'd1;
            if (DEBOUNCE_TICKS == 1) begin
              push      = 1'b1;
              push_code = 6'(row_q) * 6'(COLS) + 6'(col_low_idx);
              state_d   = StHeld;
              deb_d     = '0;
            end else begin
              state_d = StDebPress;
            end
          end else if (row_q == RW'(ROWS - 1)) begin
            state_d = StIdle;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
        StDebPress: begin
          if (!Column[col_q]) begin
            if (deb_next == DebTarget) begin
              push    = 1'b1;
              state_d = StHeld;
              deb_d   = '0;
            end else begin
              deb_d = deb_next;
            end
          end else begin
            state_d = StScan;
            deb_d   = '0;
          end
        end
        StHeld: begin
          if (Column[col_q]) begin
            if (deb_next == DebTarget) begin
              state_d = StIdle;
              row_d   = '0;
              deb_d   = '0;
            end else begin
              deb_d = deb_next;
            end
          end else begin
            deb_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (!enable_d) begin
      row_out_d = '1;
    end else if (state_d == StIdle) begin
      row_out_d = '0;
    end else begin
      row_out_d = ~(ROWS'(1) << row_d);
    end
  end

  // FIFO bookkeeping; flush beats a coincident push
  assign do_push = push && !flush;
  assign full    = (count_q == NW'(FIFO_DEPTH));
  assign wr_ok   = do_push && (!full || pop);
  assign ovf_set = do_push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({wr_ok, pop})
        2'b10:   count_d = count_q + NW'(1);
        2'b01:   count_d = count_q - NW'(1);
        default: count_d = count_q;
      endcase
    end
    ovf_d = ovf_set ? 1'b1 : (status_clr ? 1'b0 : ovf_q);
  end

  always_comb begin
    unique case (Address)
      4'h0:    rd_mux = not_empty ? {1'b1, 9'b0, mem_q[rd_ptr_q]} : 16'h0000;
      4'h2:    rd_mux = {8'b0, 5'(count_q), (state_q == StHeld), ovf_q, not_empty};
      4'h4:    rd_mux = {13'b0, irq_en, 1'b0, enable_q};
      default: rd_mux = 16'h0000;
    endcase
    rd_d = bus_rd ? rd_mux : rd_q;
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      deb_q     <= '0;
      row_out_q <= '1;
      enable_q  <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      deb_q     <= deb_d;
      row_out_q <= row_out_d;
      enable_q  <= enable_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_d;
    end
  end

  assign Row           = row_out_q;
  assign Read_data_out = rd_q;

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised successor to the CPU's 4x4 matrix keypad port: generic ROWS x COLS matrix, timed scan, per-key debounce, press-event FIFO and control register.
- Sits on the Minisys-1A I/O bus behind a chip select and returns 16-bit words to the CPU.
- Lets software read queued keystrokes without polling at scan rate.

Parameters:
- ROWS, 4, number of row lines driven (2..8).
- COLS, 4, number of column lines sampled (2..8).
- SCAN_DIV, 1000, clocks per scan tick; row dwell time (>=2).
- DEBOUNCE_TICKS, 4, consecutive matching ticks needed to accept a press or a release (1..15).
- FIFO_DEPTH, 8, key-event FIFO entries (power of 2, 2..16).

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- Select, input, 1, chip select.
- Read_enable, input, 1, bus read strobe.
- Write_enable, input, 1, bus write strobe.
- Address, input, 4, low address bits.
- Write_data, input, 16, CPU write data.
- Row, output, ROWS, row drive, active-low one-cold.
- Column, input, COLS, column sense; low = pressed.
- Read_data_out, output, 16, registered read data.

Behaviour:
- Reset (reset=0, async): Row all 1s, Read_data_out=0, FIFO empty, overflow=0, CTRL.enable=1, state IDLE, tick and debounce counters 0.
- Tick: free-running divider; pulses once every SCAN_DIV clocks while enabled. Column is sampled only on the tick, at the end of the dwell.
- Key code = row_index*COLS + col_index (6 bits). Index 0 = Row[0]/Column[0]. With several columns low, the lowest col_index wins.
- FSM states and transitions:
  - IDLE: Row all 0s. On tick with Column != all 1s, go to SCAN with row 0.
  - SCAN: drive one row low, rotating 0..ROWS-1 each tick. Column low on a tick: latch row/col, debounce count=1, go to DEB_PRESS. Full pass with no hit: back to IDLE.
  - DEB_PRESS: row held. Each tick with the same column low increments the count; any other sample returns to SCAN. When count reaches DEBOUNCE_TICKS, push code into FIFO and go to HELD. With DEBOUNCE_TICKS=1, the push happens on the first hit.
  - HELD: row held. DEBOUNCE_TICKS consecutive ticks with the latched column high go to IDLE; a low sample resets the count. No repeat pushes while held.
- CTRL.enable=0: Row all 1s, FSM forced to IDLE, divider cleared, FIFO contents kept.
- Register map (Select=1):
  - 0x0 DATA, read: {1'b1, 9'b0, code[5:0]} and pop. If FIFO is empty, returns 0x0000 with no pop.
  - 0x2 STATUS, read: [0] not_empty, [1] overflow (sticky; cleared by this read), [2] held, [7:3] count, [15:8] 0.
  - 0x4 CTRL, read/write: [0] enable, [1] flush (write 1 empties FIFO, self-clears, reads 0).
  - Other addresses: read 0x0000; writes ignored.
- Read timing: Read_data_out is updated on the clock edge where Select & Read_enable, giving a 1-cycle latency. It holds its value otherwise and is never tri-stated. The side effect (pop or clear) occurs on the same edge.
- Write timing: takes effect on the edge where Select & Write_enable. A write to 0x4 in the same cycle as a read of 0x4 returns the pre-write value.
- FIFO push and pop on the same edge: both happen, count unchanged. If the FIFO is empty, the pop returns 0x0000 and the push lands.
- Push when full: new code dropped, overflow set, existing contents intact.
- Flush coincident with push: flush wins, FIFO ends empty.
- Select=0: bus side idle, scanning continues.

Optional Feature:
- Macro: KEYPAD_SCAN_IRQ_EN.
- When defined:
  - Adds output irq (1 bit, reset 0) and CTRL[2] irq_enable (reset 0).
  - irq is registered: irq = irq_enable & (not_empty | overflow).
  - irq deasserts one cycle after the FIFO empties and overflow clears.
- When undefined: no irq port; CTRL[2] reads 0 and ignores writes.

Test Plan:
- Reset state: SCAN_DIV=4, DEBOUNCE_TICKS=2; hold reset=0 then release -> Row=4'b0000, STATUS reads 0x0000, CTRL reads 0x0001.
- Single key (row 2, col 1 low when Row[2]=0) held for 3 frames -> exactly one push; DATA reads 0x8009, then STATUS reads 0x0000.
- Bounce: column low for 1 tick then high -> no push, FIFO count 0, FSM returns to SCAN.
- Overflow: FIFO_DEPTH=8, nine distinct press/release cycles -> STATUS=0x0043 on the first read, then 0x0041; DATA returns the first 8 codes in order.
- Simultaneous pop and push on the same edge with count=3 -> count stays 3; popped value is the oldest code.
- CTRL write 0x0000 mid-DEB_PRESS -> Row=all 1s next cycle, no push. Write 0x0003 -> FIFO empty, enable=1.
